// File: rtl/guess_game_ctrl.sv
// -----------------------------------------------------------------------------
// guess_game_ctrl
//
// Controller for a "guess the sequence" game built from four symbol buttons.
// A player first enters a secret of 4..7 symbols, then other players enter
// guesses of 4..7 symbols. Each committed guess is compared position by
// position with the secret. An exact match wins. Otherwise one try is used up,
// and running out of tries loses. WON and LOST are held until reset.
//
// Parameters
//   MAX_TRIES   number of guesses allowed before loss (1..7)
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   btn[3:0]    symbol buttons (level, synchronous to clk); bit k = symbol k
//   enter       commit button (level, synchronous to clk)
//   phase[1:0]  game FSM state: 00 SECRET, 01 GUESS, 10 WON, 11 LOST
//               (this is the FSM state register itself)
//   secret_len  number of symbols stored in the secret
//   guess_len   number of symbols stored in the current guess
//   tries_left  guesses remaining
//   match[6:0]  per-position match vector of the last evaluated guess
//   win, lose   terminal result flags
//   equal, bigger, smaller
//               result / length hint flags of the last evaluation
//
// Build options
//   GUESS_HINT_EN  when defined, a failed evaluation reports a one-hot length
//                  hint (equal/bigger/smaller). When undefined, bigger and
//                  smaller are always 0 and equal is raised only on a win.
//
// Press handling: inputs are levels. A press is a rising edge seen against
// the registered copy of the input. A cycle in which several symbol buttons
// rise together is discarded entirely, including any enter edge in that
// cycle. A valid symbol press wins over an enter edge in the same cycle.
// -----------------------------------------------------------------------------
module guess_game_ctrl #(
    parameter int MAX_TRIES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       enter,
    output logic [1:0] phase,
    output logic [2:0] secret_len,
    output logic [2:0] guess_len,
    output logic [2:0] tries_left,
    output logic [6:0] match,
    output logic       win,
    output logic       lose,
    output logic       equal,
    output logic       bigger,
    output logic       smaller
);

    typedef enum logic [1:0] {
        PH_SECRET = 2'b00,
        PH_GUESS  = 2'b01,
        PH_WON    = 2'b10,
        PH_LOST   = 2'b11
    } phase_t;

    localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);
    localparam logic [2:0] LEN_MAX    = 3'd7;
    localparam logic [2:0] LEN_MIN    = 3'd4;

    // State and datapath registers with their next values
    phase_t          state_q, state_d;
    logic [6:0][1:0] secret_q, secret_d;
    logic [6:0][1:0] guess_q, guess_d;
    logic [2:0]      slen_q, slen_d;
    logic [2:0]      glen_q, glen_d;
    logic [2:0]      tries_q, tries_d;
    logic [6:0]      match_q, match_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;
    logic            equal_q, equal_d;
    logic            bigger_q, bigger_d;
    logic            smaller_q, smaller_d;

    // Edge detection
    logic [3:0]      btn_q;
    logic            enter_q;
    logic [3:0]      rise;
    logic            enter_rise;
    logic            multi_rise;
    logic            sym_valid;
    logic            enter_valid;
    logic [1:0]      sym;

    // Combinational compare of the current guess against the secret
    logic [6:0]      match_c;

    assign rise        = btn & ~btn_q;
    assign enter_rise  = enter & ~enter_q;
    // Clearing the lowest set bit leaves a nonzero value only if 2+ bits rose
    assign multi_rise  = (rise & (rise - 4'd1)) != 4'd0;
    assign sym_valid   = (rise != 4'd0) && !multi_rise;
    // Any symbol activity in the cycle, valid or not, swallows the enter edge
    assign enter_valid = enter_rise && (rise == 4'd0);

    always_comb begin
        sym = 2'd0;
        if (rise[1]) sym = 2'd1;
        if (rise[2]) sym = 2'd2;
        if (rise[3]) sym = 2'd3;
    end

    // A position matches when it is empty in both arrays, or filled in both
    // with the same symbol. Filled-versus-empty never matches, even though
    // empty slots hold code 0.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < 7; i++) begin
            match_c[i] = ((3'(i) >= slen_q) && (3'(i) >= glen_q)) ||
                         ((3'(i) <  slen_q) && (3'(i) <  glen_q) &&
                          (secret_q[i] == guess_q[i]));
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        slen_d    = slen_q;
        glen_d    = glen_q;
        tries_d   = tries_q;
        match_d   = match_q;
        win_d     = win_q;
        lose_d    = lose_q;
        equal_d   = equal_q;
        bigger_d  = bigger_q;
        smaller_d = smaller_q;

        case (state_q)
            PH_SECRET: begin
                if (slen_q == LEN_MAX) begin
                    // A full secret commits itself one cycle later
                    state_d = PH_GUESS;
                end else if (sym_valid) begin
                    secret_d[slen_q] = sym;
                    slen_d           = slen_q + 3'd1;
                end else if (enter_valid && (slen_q >= LEN_MIN)) begin
                    state_d = PH_GUESS;
                end
            end

            PH_GUESS: begin
                if (sym_valid) begin
                    if (glen_q != LEN_MAX) begin
                        guess_d[glen_q] = sym;
                        glen_d          = glen_q + 3'd1;
                    end
                end else if (enter_valid && (glen_q >= LEN_MIN)) begin
                    match_d = match_c;
                    if (match_c == 7'h7F) begin
                        state_d   = PH_WON;
                        win_d     = 1'b1;
                        equal_d   = 1'b1;
                        bigger_d  = 1'b0;
                        smaller_d = 1'b0;
                    end else begin
                        tries_d = tries_q - 3'd1;
                        guess_d = '0;
                        glen_d  = 3'd0;
`ifdef GUESS_HINT_EN
                        equal_d   = (glen_q == slen_q);
                        bigger_d  = (glen_q <  slen_q);
                        smaller_d = (glen_q >  slen_q);
`else
                        equal_d   = 1'b0;
                        bigger_d  = 1'b0;
                        smaller_d = 1'b0;
`endif
                        if (tries_q == 3'd1) begin
                            state_d = PH_LOST;
                            lose_d  = 1'b1;
                        end
                    end
                end
            end

            PH_WON, PH_LOST: begin
                // Terminal: everything holds until reset
            end

            default: state_d = PH_SECRET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= PH_SECRET;
            secret_q  <= '0;
            guess_q   <= '0;
            slen_q    <= 3'd0;
            glen_q    <= 3'd0;
            tries_q   <= TRIES_INIT;
            match_q   <= 7'd0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            equal_q   <= 1'b0;
            bigger_q  <= 1'b0;
            smaller_q <= 1'b0;
            btn_q     <= 4'd0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            secret_q  <= secret_d;
            guess_q   <= guess_d;
            slen_q    <= slen_d;
            glen_q    <= glen_d;
            tries_q   <= tries_d;
            match_q   <= match_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            equal_q   <= equal_d;
            bigger_q  <= bigger_d;
            smaller_q <= smaller_d;
            btn_q     <= btn;
            enter_q   <= enter;
        end
    end

    assign phase      = state_q;
    assign secret_len = slen_q;
    assign guess_len  = glen_q;
    assign tries_left = tries_q;
    assign match      = match_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign equal      = equal_q;
    assign bigger     = bigger_q;
    assign smaller    = smaller_q;

endmodule
